multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle sequencer for the RV32 core datapath: a FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM.
//  Drives the per-cycle datapath strobes (PC, IR, register file, ALU, data memory) for
//  R-type, I-type (addi), LW and SW, using a ready handshake to shared instruction/data memory.
//  Also provides retire counting, a memory timeout and a sticky trap for illegal opcodes and bus errors.
// PARAMETERS
//  MEM_TIMEOUT  15  cycles to wait for mem_ready in FETCH/MEM before trapping (range 1..255)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  opcode      in   7      instr[6:0] from IR, valid from DECODE onward
//  mem_ready   in   1      memory access complete this cycle
//  stall       in   1      freeze sequencing (hazard/debug)
//  pcWrite     out  1      PC <= PC+4 strobe
//  irWrite     out  1      IR load strobe
//  regWrite    out  1      register file write strobe
//  aluSrc      out  1      0: rs2 operand, 1: immediate
//  memRead     out  1      memory read request (fetch or LW)
//  memWrite    out  1      memory write request (SW)
//  aluControl  out  3      ALU op; 3'b000 (add) for all supported classes
//  state       out  3      current FSM state, for debug
//  retire      out  1      1-cycle pulse when an instruction completes
//  instr_count out  CNT_W  retired instruction count, wraps modulo 2^CNT_W
//  illegal     out  1      sticky: unsupported opcode decoded
//  bus_error   out  1      sticky: mem_ready timeout
// BEHAVIOUR
//  Encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Codes 6 and 7 are unreachable and go to TRAP.
//  Reset: state=FETCH; instr_count=0; illegal=0; bus_error=0; timeout counter=0; opcode class reg=R.
//   While rst=1, all strobe outputs are 0. memRead=1 from the first cycle after rst falls.
//  Class: R=0110011, I=0010011, LW=0000011, SW=0100011. Class is latched in DECODE.
//  FETCH: memRead=1. On mem_ready: irWrite=1 and pcWrite=1 in the same cycle, then -> DECODE.
//  DECODE: latch class; illegal opcode -> TRAP and set illegal. Otherwise -> EXECUTE. No strobes.
//  EXECUTE: aluSrc=0 for R, 1 otherwise; aluControl=000. R/I -> WRITEBACK; LW/SW -> MEM.
//  MEM: aluSrc=1. LW: memRead=1; SW: memWrite=1. Request is held until mem_ready.
//   LW + mem_ready -> WRITEBACK. SW + mem_ready -> FETCH with retire=1.
//  WRITEBACK: regWrite=1 for exactly one cycle; retire=1; -> FETCH.
//  retire increments instr_count in the same edge. Wrap from all-ones to 0 is silent.
//  Timeout: counter clears on entering FETCH or MEM and increments each non-stalled waiting cycle.
//   If it reaches MEM_TIMEOUT with mem_ready=0, go -> TRAP and set bus_error.
//   mem_ready on the same cycle the count reaches MEM_TIMEOUT wins; no trap.
//  TRAP: all strobes 0, retire 0. Stays in TRAP until rst; illegal/bus_error hold.
//  stall=1 (any state but TRAP): state, class, counters frozen.
//   pcWrite/irWrite/regWrite/memWrite/memRead/retire forced 0; mem_ready is ignored.
//   The access is re-requested when stall falls; memory must re-handshake.
//  mem_ready outside FETCH/MEM is ignored.
//  Latency with mem_ready=1 on the first request cycle: R/I 4 cycles, SW 4, LW 5 (FETCH..retire).
//  rst mid-operation: an in-flight access is abandoned. Next cycle is FETCH with no write strobe.
// TESTING
//  1. rst 2 cycles, opcode=0110011, mem_ready=1 always.
//     -> states 0,1,2,4 repeat; regWrite every 4th cycle; instr_count=3 after 12 cycles.
//  2. LW, mem_ready=1 after 2 wait cycles in both FETCH and MEM.
//     -> memRead high 3 cycles each; aluSrc=1; regWrite once; total 9 cycles.
//  3. SW, mem_ready=1 -> memWrite=1 one cycle in MEM, regWrite never 1, retire on MEM exit, 4-cycle loop.
//  4. opcode=1100011 -> TRAP after DECODE, illegal=1, all strobes 0 for 20 cycles; rst clears to FETCH.
//  5. mem_ready=0 in FETCH -> bus_error=1 and TRAP exactly MEM_TIMEOUT cycles after entry.
//     Variant: mem_ready on cycle MEM_TIMEOUT -> no trap.
//  6. stall=1 for 3 cycles in MEM (SW) with mem_ready=1 -> memWrite=0, state holds 3, then completes.
//     Also: rst asserted in MEM -> FETCH, instr_count=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Sequencer bus: opcode/memory handshake inputs and datapath strobes.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             stall;
  logic             pcWrite;
  logic             irWrite;
  logic             regWrite;
  logic             aluSrc;
  logic             memRead;
  logic             memWrite;
  logic [2:0]       aluControl;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             illegal;
  logic             bus_error;

  modport master (
    input  opcode, mem_ready, stall,
    output pcWrite, irWrite, regWrite, aluSrc,
    output memRead, memWrite, aluControl, state,
    output retire, instr_count, illegal, bus_error
  );

  modport slave (
    output opcode, mem_ready, stall,
    input  pcWrite, irWrite, regWrite, aluSrc,
    input  memRead, memWrite, aluControl, state,
    input  retire, instr_count, illegal, bus_error
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM
// with retire counter, memory timeout and sticky trap.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_R, C_I, C_LW, C_SW
  } cls_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             berr_q, berr_d;

  cls_e op_cls;
  logic op_ok;
  logic pc_w, ir_w, rg_w, alu_s, m_rd, m_wr, ret;

  // Opcode class decode
  always_comb begin
    op_cls = C_R;
    op_ok  = 1'b1;
    unique case (bus.opcode)
      OP_R:    op_cls = C_R;
      OP_I:    op_cls = C_I;
      OP_LW:   op_cls = C_LW;
      OP_SW:   op_cls = C_SW;
      default: op_ok  = 1'b0;
    endcase
  end

  // Next-state, strobes, timeout and sticky flags
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    berr_d  = berr_q;
    pc_w    = 1'b0;
    ir_w    = 1'b0;
    rg_w    = 1'b0;
    alu_s   = 1'b0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    ret     = 1'b0;
    case (state_q)
      S_FETCH: if (!bus.stall) begin
        m_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: if (!bus.stall) begin
        if (op_ok) begin
          cls_d   = op_cls;
          state_d = S_EXEC;
        end else begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_s = (cls_q != C_R);
        if (!bus.stall) begin
          if (cls_q == C_LW || cls_q == C_SW) begin
            tmo_d   = '0;
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        alu_s = 1'b1;
        if (!bus.stall) begin
          m_rd = (cls_q == C_LW);
          m_wr = (cls_q == C_SW);
          if (bus.mem_ready) begin
            if (cls_q == C_SW) begin
              ret     = 1'b1;
              tmo_d   = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (tmo_q == TMO_LAST) begin
            berr_d  = 1'b1;
            state_d = S_TRAP;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      S_WB: if (!bus.stall) begin
        rg_w    = 1'b1;
        ret     = 1'b1;
        tmo_d   = '0;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    cnt_d = cnt_q + CNT_W'(ret);
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      tmo_q   <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.pcWrite     = pc_w  & ~rst;
  assign bus.irWrite     = ir_w  & ~rst;
  assign bus.regWrite    = rg_w  & ~rst;
  assign bus.aluSrc      = alu_s & ~rst;
  assign bus.memRead     = m_rd  & ~rst;
  assign bus.memWrite    = m_wr  & ~rst;
  assign bus.retire      = ret   & ~rst;
  assign bus.aluControl  = 3'b000;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;
  assign bus.illegal     = ill_q;
  assign bus.bus_error   = berr_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller plus
// directed checks for sequencing, traps, timeout, stall and reset.
module tb_multicycle_controller;
  localparam int TMO = 15;
  localparam int CW  = 32;
  localparam int NI  = 60;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CW)) bus ();

  multicycle_controller #(
    .MEM_TIMEOUT(TMO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int rd;
    int wr;
    int rg;
    int asrc;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;
  bit   mon_en = 1'b0;
  int   exp_cnt = 0;
  int   n_rd, n_wr, n_rg, e_asrc, mem_asrc_bad;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic clr_mon();
    n_rd = 0;
    n_wr = 0;
    n_rg = 0;
    e_asrc = -1;
    mem_asrc_bad = 0;
  endtask

  // Scoreboard monitor: pops one expectation per retire pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.memRead)  n_rd++;
        if (bus.memWrite) n_wr++;
        if (bus.regWrite) n_rg++;
        if (bus.state == 3'd2) e_asrc = int'(bus.aluSrc);
        if (bus.state == 3'd3 && !bus.aluSrc) mem_asrc_bad++;
        if (bus.retire) begin
          if (sbq.size() == 0) begin
            chk("unexpected_retire", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("memRead_cycles", n_rd, e.rd);
            chk("memWrite_cycles", n_wr, e.wr);
            chk("regWrite_cycles", n_rg, e.rg);
            chk("exec_aluSrc", e_asrc, e.asrc);
            chk("mem_aluSrc_low", mem_asrc_bad, 0);
            chk("instr_count", bus.instr_count, exp_cnt);
            exp_cnt++;
          end
          clr_mon();
        end
      end
    end
  endtask

  initial begin
    int seq[4] = '{0, 1, 2, 4};
    logic [6:0] ops[4] = '{OP_R, OP_I, OP_LW, OP_SW};
    logic [6:0] curop;
    int pushed, cyc, wc, fw, mw, bad;
    bit have, stl, rdy;
    exp_t e;

    fork
      monitor();
    join_none

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = OP_R;
    tick();
    @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_memRead", bus.memRead, 0);
    chk("rst_regWrite", bus.regWrite, 0);
    chk("rst_count", bus.instr_count, 0);
    chk("rst_flags", {bus.illegal, bus.bus_error}, 0);
    tick();

    // R-type loop with ready always high
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rloop_state", bus.state, seq[i % 4]);
      chk("rloop_regWrite", bus.regWrite, (i % 4) == 3);
      tick();
    end
    @(negedge clk);
    chk("rloop_count", bus.instr_count, 3);
    tick();

    // Randomized phase against the scoreboard
    do_rst();
    clr_mon();
    exp_cnt = 0;
    mon_en = 1'b1;
    pushed = 0;
    cyc = 0;
    have = 1'b0;
    wc = 0;
    fw = 0;
    mw = 0;
    curop = OP_R;
    while ((pushed < NI || sbq.size() != 0) && cyc < 20000) begin
      stl = (pushed < NI) && ($urandom_range(0, 7) == 0);
      rdy = 1'($urandom_range(0, 1));
      if (!stl && bus.state == 3'd0) begin
        if (!have && pushed < NI) begin
          curop = ops[$urandom_range(0, 3)];
          fw = $urandom_range(0, 4);
          mw = $urandom_range(0, 4);
          wc = 0;
          have = 1'b1;
        end
        if (!have) begin
          rdy = 1'b0;
        end else if (wc == fw) begin
          rdy = 1'b1;
          bus.opcode = curop;
          e.rd = fw + 1 + ((curop == OP_LW) ? mw + 1 : 0);
          e.wr = (curop == OP_SW) ? mw + 1 : 0;
          e.rg = (curop == OP_SW) ? 0 : 1;
          e.asrc = (curop == OP_R) ? 0 : 1;
          sbq.push_back(e);
          pushed++;
          have = 1'b0;
          wc = 0;
        end else begin
          rdy = 1'b0;
          wc++;
        end
      end else if (!stl && bus.state == 3'd3) begin
        if (wc == mw) begin
          rdy = 1'b1;
        end else begin
          rdy = 1'b0;
          wc++;
        end
      end
      bus.stall = stl;
      bus.mem_ready = rdy;
      tick();
      cyc++;
    end
    chk("random_drained", sbq.size() + ((cyc >= 20000) ? 1 : 0), 0);
    chk("random_retired", exp_cnt, NI);
    chk("random_flags", {bus.illegal, bus.bus_error}, 0);
    mon_en = 1'b0;

    // Illegal opcode: trap after DECODE, strobes quiet
    do_rst();
    bus.opcode = OP_BR;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.state != 3'd5 || bus.illegal !== 1'b1) bad++;
      if (|{bus.pcWrite, bus.irWrite, bus.regWrite, bus.memRead,
            bus.memWrite, bus.retire}) bad++;
      tick();
    end
    chk("illegal_trap_cycles_bad", bad, 0);
    do_rst();
    @(negedge clk);
    chk("illegal_rst_state", bus.state, 0);
    chk("illegal_rst_flag", bus.illegal, 0);
    chk("illegal_rst_memRead", bus.memRead, 1);
    tick();

    // Fetch timeout traps exactly TMO cycles after entry
    do_rst();
    for (int i = 0; i <= TMO; i++) begin
      @(negedge clk);
      if (i == TMO - 1) chk("tmo_pre_state", bus.state, 0);
      if (i == TMO) begin
        chk("tmo_state", bus.state, 5);
        chk("tmo_bus_error", bus.bus_error, 1);
      end
      tick();
    end

    // Ready on the last waiting cycle wins
    do_rst();
    bus.opcode = OP_R;
    for (int i = 0; i <= TMO; i++) begin
      bus.mem_ready = (i == TMO - 1);
      @(negedge clk);
      if (i == TMO) begin
        chk("tmo_win_state", bus.state, 1);
        chk("tmo_win_bus_error", bus.bus_error, 0);
      end
      tick();
    end

    // SW stalled in MEM for 3 cycles
    do_rst();
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.stall = (i >= 3 && i <= 5);
      @(negedge clk);
      if (i >= 3 && i <= 5) begin
        chk("stall_memWrite", bus.memWrite, 0);
        chk("stall_state", bus.state, 3);
      end
      if (i == 6) begin
        chk("unstall_memWrite", bus.memWrite, 1);
        chk("unstall_retire", bus.retire, 1);
        chk("sw_regWrite", bus.regWrite, 0);
      end
      if (i == 7) begin
        chk("sw_done_state", bus.state, 0);
        chk("sw_done_count", bus.instr_count, 1);
      end
      tick();
    end

    // Reset while LW waits in MEM
    do_rst();
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("lw_mem_memRead", bus.memRead, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", {bus.memRead, bus.regWrite, bus.memWrite}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", bus.state, 0);
    chk("midrst_count", bus.instr_count, 0);
    chk("midrst_strobes2", {bus.memRead, bus.regWrite, bus.memWrite}, 3'b100);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
